data_generator: RTL and testbench
=================================

Name: data_generator

Overview:
- Produces a Size-bit test data word that the user adjusts with three active-low push-buttons: Up, Down and Reset.
- Each button input is synchronised and debounced.
- A press of Up or Down steps the value by one. Holding the button auto-repeats after an initial pause.
- The block feeds manual stimulus values into downstream datapaths on an FPGA board.

Parameters:
- Size, 3: width of Data in bits (≥2).
- Signed, "Yes": "Yes" means Data is two's complement (range -2^(Size-1) .. 2^(Size-1)-1); any other string means unsigned (range 0 .. 2^Size-1).
- ClockPeriod_ns, 20: Clock period in ns, used only to derive cycle counts.
- FilterPeriod_ns, 100: debounce stability time.
- PauseInterval_ns, 2500: hold time from accepted press to first auto-repeat.
- RepeatsInterval_ns, 1500: period between subsequent auto-repeats.

Ports:
- Clock  in  1  system clock; all state updates on its rising edge.
- Reset  in  1  asynchronous, active-high system reset.
- Button_Up  in  1  active-low, asynchronous button; increments Data.
- Button_Reset  in  1  active-low, asynchronous button; clears Data to 0.
- Button_Down  in  1  active-low, asynchronous button; decrements Data.
- Data  out  Size  current value, registered.

Behaviour:
- Derived cycle counts use integer division, with a minimum of 1:
  - FilterCycles = FilterPeriod_ns/ClockPeriod_ns, which is 5 by default.
  - PauseCycles = PauseInterval_ns/ClockPeriod_ns, which is 125 by default.
  - RepeatCycles = RepeatsInterval_ns/ClockPeriod_ns, which is 75 by default.
- Reset=1 (async) behaviour:
  - Data=0.
  - Synchroniser flops preset to 1 (released).
  - Debounced states = released.
  - All counters cleared.
- Input path, per button:
  - 2-flop synchroniser.
  - Debouncer: the debounced state changes only after the synchronised input has differed from it for FilterCycles consecutive clocks.
  - Any sample that equals the current debounced state restarts the debounce count.
  - Pulses shorter than FilterCycles clocks are ignored.
  - A pulse of exactly FilterCycles clocks (100 ns) is accepted.
- Step events for Up and Down, generated independently:
  - One event on the clock the debounced state becomes pressed.
  - While the button is still pressed: one event PauseCycles clocks after the press event, then one every RepeatCycles clocks.
  - Release (debounced) stops repeats immediately and clears that button's timer.
- Data update (registered, same clock as the event):
  - Up event alone: Data+1, saturating at the maximum (3 signed / 7 unsigned for Size=3).
  - Down event alone: Data-1, saturating at the minimum (-4, i.e. 3'b100, signed / 0 unsigned).
  - Up and Down events in the same clock cancel: Data unchanged.
  - While Button_Reset is debounced-pressed, Data is forced to 0 each clock and Up/Down events are discarded. Up/Down repeat timers keep running.
  - Repeats after Reset release resume on the held button's existing cadence; no new initial pause.
- No wrap-around: saturation applies at both ends.
- Latency: from a clean button edge to the Data change is 2 (sync) + FilterCycles + 1 clocks, i.e. 8 clocks by default.
- Reset asserted mid-operation overrides everything; after deassertion, a button still held low is seen as a new press.

Test Plan:
- Power-up: Reset=1 then 0, all buttons=1 -> Data=0 and stays 0.
- Up held 13 µs from Data=0 (Signed="Yes"):
  - Data=1 about 160 ns after press; 2 at +2.5 µs; 3 at +4.0 µs.
  - Stays 3 (saturated) until release.
- Then Down held 13 µs:
  - Data=2 on press, then 1, 0, -1, -2, -3 at +2.5, 4.0, 5.5, 7.0, 8.5 µs.
  - Data=-4 at +10.0 µs and stays -4.
- Short presses: Up low 1 µs -> exactly one step (-4 → -3). Down low 1 µs -> back to -4. No repeats.
- Glitch: Button_Up low for 60 ns (3 clocks) -> Data unchanged.
- Reset during hold:
  - Up held; after 5 µs, Button_Reset low 100 ns -> Data=0 about 8 clocks after the Reset edge. Up events are ignored while Reset is pressed.
  - With Up still held, the next repeat on the existing 1.5 µs cadence gives Data=1; later repeats saturate at 3.
  - Up released -> no further change.

Source files
------------

// File: rtl/data_generator.sv
// ============================================================================
// Module   : data_generator
// Purpose  : Push-button driven Size-bit test word with debounce, auto-repeat
//            and saturation at both ends.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module data_generator #(
  parameter int    Size               = 3,
  parameter string Signed             = "Yes",
  parameter int    ClockPeriod_ns     = 20,
  parameter int    FilterPeriod_ns    = 100,
  parameter int    PauseInterval_ns   = 2500,
  parameter int    RepeatsInterval_ns = 1500
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            Button_Up,
  input  logic            Button_Reset,
  input  logic            Button_Down,
  output logic [Size-1:0] Data
);

  localparam int c_FILTER_CYCLES = (FilterPeriod_ns / ClockPeriod_ns) < 1 ? 1
                                 : (FilterPeriod_ns / ClockPeriod_ns);
  localparam int c_PAUSE_CYCLES  = (PauseInterval_ns / ClockPeriod_ns) < 1 ? 1
                                 : (PauseInterval_ns / ClockPeriod_ns);
  localparam int c_REPEAT_CYCLES = (RepeatsInterval_ns / ClockPeriod_ns) < 1 ? 1
                                 : (RepeatsInterval_ns / ClockPeriod_ns);
  localparam int c_TMR_MAX       = (c_PAUSE_CYCLES > c_REPEAT_CYCLES) ? c_PAUSE_CYCLES
                                 : c_REPEAT_CYCLES;
  localparam int c_DB_W          = (c_FILTER_CYCLES > 1) ? $clog2(c_FILTER_CYCLES) : 1;
  localparam int c_TMR_W         = $clog2(c_TMR_MAX + 1);
  localparam bit c_SIGNED        = (Signed == "Yes");

  localparam logic [c_DB_W-1:0]  c_DB_LAST   = c_DB_W'(c_FILTER_CYCLES - 1);
  localparam logic [c_TMR_W-1:0] c_PAUSE_TGT = c_TMR_W'(c_PAUSE_CYCLES);
  localparam logic [c_TMR_W-1:0] c_REP_TGT   = c_TMR_W'(c_REPEAT_CYCLES);
  localparam logic [Size-1:0]    c_MAX       = c_SIGNED ? {1'b0, {(Size-1){1'b1}}}
                                             : {Size{1'b1}};
  localparam logic [Size-1:0]    c_MIN       = c_SIGNED ? {1'b1, {(Size-1){1'b0}}}
                                             : {Size{1'b0}};

  // Bit order for all per-button vectors: [0]=Up, [1]=Down, [2]=Reset (1 = released)
  logic [2:0]      w_btn_raw;
  logic [2:0]      r_sync1;
  logic [2:0]      r_sync2;
  logic [2:0]      w_db;
  logic [2:0]      r_db_q;
  logic [1:0]      w_press;
  logic [1:0]      w_evt;
  logic [Size-1:0] r_data;

  assign w_btn_raw = {Button_Reset, Button_Down, Button_Up};

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_sync1 <= 3'b111;
      r_sync2 <= 3'b111;
      r_db_q  <= 3'b111;
    end else begin
      r_sync1 <= w_btn_raw;
      r_sync2 <= r_sync1;
      r_db_q  <= w_db;
    end
  end

  // Debounced state flips only after c_FILTER_CYCLES consecutive differing samples
  for (genvar gi = 0; gi < 3; gi++) begin : g_debounce
    logic              r_state;
    logic [c_DB_W-1:0] r_cnt;

    always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
        r_state <= 1'b1;
        r_cnt   <= '0;
      end else if (r_sync2[gi] == r_state) begin
        r_cnt   <= '0;
      end else if (r_cnt == c_DB_LAST) begin
        r_state <= r_sync2[gi];
        r_cnt   <= '0;
      end else begin
        r_cnt   <= r_cnt + 1'b1;
      end
    end

    assign w_db[gi] = r_state;
  end

  assign w_press = ~w_db[1:0] & r_db_q[1:0];

  // Per-direction step events: press, then one after the pause, then periodic
  for (genvar gi = 0; gi < 2; gi++) begin : g_repeat
    logic               r_rep;
    logic [c_TMR_W-1:0] r_tmr;
    logic               w_timed;

    assign w_timed   = ~w_db[gi] & (r_tmr == (r_rep ? c_REP_TGT : c_PAUSE_TGT));
    assign w_evt[gi] = w_press[gi] | w_timed;

    always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
        r_tmr <= '0;
        r_rep <= 1'b0;
      end else if (w_db[gi]) begin
        r_tmr <= '0;
        r_rep <= 1'b0;
      end else if (w_press[gi]) begin
        r_tmr <= c_TMR_W'(1);
        r_rep <= 1'b0;
      end else if (w_timed) begin
        r_tmr <= c_TMR_W'(1);
        r_rep <= 1'b1;
      end else begin
        r_tmr <= r_tmr + 1'b1;
      end
    end
  end

  // Reset button dominates; simultaneous Up/Down events cancel out
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_data <= '0;
    end else if (!w_db[2]) begin
      r_data <= '0;
    end else if (w_evt == 2'b01 && r_data != c_MAX) begin
      r_data <= r_data + 1'b1;
    end else if (w_evt == 2'b10 && r_data != c_MIN) begin
      r_data <= r_data - 1'b1;
    end
  end

  assign Data = r_data;

endmodule

`default_nettype wire

// File: tb/tb_data_generator.sv
// ============================================================================
// Module   : tb_data_generator
// Purpose  : Scoreboard bench for data_generator with a cycle-history model.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_data_generator;

  localparam int c_F    = 5;
  localparam int c_P    = 125;
  localparam int c_R    = 75;
  localparam int c_MAXV = 3;
  localparam int c_MINV = -4;
  localparam int c_HIST = 32768;

  logic       clk       = 1'b0;
  logic       rst       = 1'b1;
  logic       btn_up    = 1'b1;
  logic       btn_down  = 1'b1;
  logic       btn_reset = 1'b1;
  logic [2:0] data;

  typedef struct {
    logic [2:0] val;
    int         at_edge;
  } exp_t;

  exp_t       exp_q[$];
  int         n_checks  = 0;
  int         n_fail    = 0;
  int         cur_edge  = 0;
  int         model_val = 0;
  logic [2:0] hist[c_HIST];

  always #10 clk = ~clk;

  data_generator dut (
    .Clock        (clk),
    .Reset        (rst),
    .Button_Up    (btn_up),
    .Button_Reset (btn_reset),
    .Button_Down  (btn_down),
    .Data         (data)
  );

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d at edge %0d", name, $signed(act), $signed(req),
               cur_edge);
    end
  endtask

  task automatic hold(input logic u, input logic d, input logic r, input int n);
    btn_up    = u;
    btn_down  = d;
    btn_reset = r;
    repeat (n) @(negedge clk);
  endtask

  // Reference model: debounced level = last F delayed samples all disagree with it
  initial begin : model
    bit   db[3];
    int   press_e[2];
    bit   ev[2];
    bit   all_diff;
    logic s;
    int   idx;
    int   d;
    int   nv;
    exp_t x;
    db      = '{1'b1, 1'b1, 1'b1};
    press_e = '{0, 0};
    forever begin
      @(posedge clk);
      if (!rst && cur_edge < c_HIST - 1) begin
        cur_edge++;
        hist[cur_edge] = {btn_reset, btn_down, btn_up};
        for (int b = 0; b < 3; b++) begin
          all_diff = 1'b1;
          for (int k = 0; k < c_F; k++) begin
            idx = cur_edge - 2 - k;
            s   = (idx >= 1) ? hist[idx][b] : 1'b1;
            if (s == db[b]) all_diff = 1'b0;
          end
          if (all_diff) begin
            db[b] = ~db[b];
            if (b < 2 && db[b] == 1'b0) press_e[b] = cur_edge;
          end
        end
        for (int b = 0; b < 2; b++) begin
          ev[b] = 1'b0;
          if (db[b] == 1'b0) begin
            d     = cur_edge - press_e[b];
            ev[b] = (d == 0) || (d == c_P) || (d > c_P && ((d - c_P) % c_R) == 0);
          end
        end
        nv = model_val;
        if (db[2] == 1'b0)          nv = 0;
        else if (ev[0] && !ev[1])   nv = (model_val < c_MAXV) ? model_val + 1 : model_val;
        else if (ev[1] && !ev[0])   nv = (model_val > c_MINV) ? model_val - 1 : model_val;
        if (nv != model_val) begin
          x.val     = 3'(nv);
          x.at_edge = cur_edge + 1;
          exp_q.push_back(x);
        end
        model_val = nv;
      end
    end
  end

  // Monitor: every change of Data must match the next expected value and edge
  initial begin : monitor
    logic [2:0] prev;
    exp_t       x;
    prev = 3'd0;
    forever begin
      @(negedge clk);
      if (!rst && data !== prev) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_change: got %0d required no change at edge %0d",
                   $signed(data), cur_edge);
        end else begin
          x = exp_q.pop_front();
          check("data_value", data, x.val);
          n_checks++;
          if (x.at_edge != cur_edge) begin
            n_fail++;
            $display("FAIL data_timing: got edge %0d required edge %0d", cur_edge, x.at_edge);
          end
        end
        prev = data;
      end
    end
  end

  initial begin : watchdog
    #(20 * 60000);
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "simulation timeout");
  end

  initial begin : stimulus
    logic [2:0] mv;
    int         n;
    logic       u, dn, r;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_data", data, 3'd0);
    rst = 1'b0;
    hold(1, 1, 1, 50);   check("powerup_idle", data, 3'd0);
    hold(0, 1, 1, 650);  hold(1, 1, 1, 30); check("up_saturate", data, 3'd3);
    hold(1, 0, 1, 650);  hold(1, 1, 1, 30); check("down_saturate", data, 3'b100);
    hold(0, 1, 1, 50);   hold(1, 1, 1, 30); check("short_up", data, 3'b101);
    hold(1, 0, 1, 50);   hold(1, 1, 1, 30); check("short_down", data, 3'b100);
    hold(0, 1, 1, 3);    hold(1, 1, 1, 30); check("glitch_up", data, 3'b100);
    hold(0, 1, 1, 4);    hold(1, 1, 1, 30); check("pulse_below_filter", data, 3'b100);
    hold(0, 1, 1, 5);    hold(1, 1, 1, 30); check("pulse_at_filter", data, 3'b101);
    hold(0, 1, 1, 250);  hold(0, 1, 0, 5);  hold(0, 1, 1, 20);
    check("reset_during_hold", data, 3'd0);
    hold(0, 1, 1, 380);  hold(1, 1, 1, 30); check("resume_saturate", data, 3'd3);
    hold(0, 0, 1, 300);  hold(1, 1, 1, 30); check("up_down_cancel", data, 3'd3);

    for (int i = 0; i < 60; i++) begin
      u  = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
      dn = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
      r  = ($urandom_range(0, 5) == 0) ? 1'b0 : 1'b1;
      n  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : int'($urandom_range(10, 300));
      hold(u, dn, r, n);
    end
    hold(1, 1, 1, 200);

    for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: got %0d pending required 0", exp_q.size());
    end
    mv = model_val[2:0];
    check("final_value", data, mv);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
